// File: rtl/local_ram_if.sv
// local_ram_if: native valid/ready memory bus responder fronting a byte-lane local RAM.
// Decodes a WORDS*4-byte window at BASE_ADDR, issues RAM strobes combinationally in
// IDLE, acks writes after 1 cycle and reads after 2 cycles.
// Optional write protection of the low WP_WORDS words: define LOCAL_RAM_IF_WP_EN.
module local_ram_if #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORDS     = 256,
    parameter int unsigned ADDR_BITS = 11,
    parameter int unsigned WP_WORDS  = 64
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic [3:0]           ram_wr,
    output logic                 ram_rd,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata,
    output logic                 wp_violation
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

    // 33-bit window math so BASE_ADDR + size cannot wrap
    localparam logic [32:0] WIN_BASE = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_SIZE = 33'(WORDS) << 2;

    state_t      state_q;
    state_t      state_d;
    logic [32:0] win_off;
    logic        sel;
    logic        is_write;
    logic        wr_blocked;
    logic        wp_hit;

    // Address decode: offset into the window; below-base addresses wrap above WIN_SIZE
    assign win_off   = {1'b0, mem_addr} - WIN_BASE;
    assign sel       = mem_valid && (win_off < WIN_SIZE);
    assign is_write  = (mem_wstrb != 4'h0);
    assign ram_addr  = mem_addr[ADDR_BITS+1:2];
    assign ram_wdata = mem_wdata;

`ifdef LOCAL_RAM_IF_WP_EN
    localparam logic [30:0] WP_LIMIT = 31'(WP_WORDS);

    // Writes to the low protected words are swallowed but still acknowledged
    assign wr_blocked = (win_off[32:2] < WP_LIMIT);

    // Sticky protection-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wp_violation <= 1'b0;
        end else if (wp_hit) begin
            wp_violation <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_instr};
`else
    assign wr_blocked   = 1'b0;
    assign wp_violation = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_instr, wp_hit, 1'(WP_WORDS)};
`endif

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and RAM strobe decode; strobes only ever fire in IDLE
    always_comb begin
        state_d = state_q;
        ram_wr  = 4'h0;
        ram_rd  = 1'b0;
        wp_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel) begin
                    if (is_write) begin
                        ram_wr  = wr_blocked ? 4'h0 : mem_wstrb;
                        wp_hit  = wr_blocked;
                        state_d = ACK;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse registered alongside the ACK state
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= (state_d == ACK);
        end
    end

    // Read data capture; holds its value outside RD_WAIT
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mem_rdata <= 32'h0;
        end else if (state_q == RD_WAIT) begin
            mem_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_local_ram_if.sv
// tb_local_ram_if: directed + randomized bench for local_ram_if with a behavioural
// RAM device and a transaction-level memory model. Build with LOCAL_RAM_IF_WP_EN
// to exercise write protection.
module tb_local_ram_if;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 256;
    localparam int unsigned AB    = 11;
    localparam int unsigned WPW   = 64;
`ifdef LOCAL_RAM_IF_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_;
    logic          mem_valid;
    logic          mem_instr;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [3:0]    ram_wr;
    logic          ram_rd;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          wp_violation;

    local_ram_if #(
        .BASE_ADDR(BASE),
        .WORDS    (WORDS),
        .ADDR_BITS(AB),
        .WP_WORDS (WPW)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ram_wr      (ram_wr),
        .ram_rd      (ram_rd),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .wp_violation(wp_violation)
    );

    always #5 clk = ~clk;

    // Behavioural byte-lane RAM device with 1-cycle registered read
    logic [31:0] dev_mem [WORDS];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wr[b]) dev_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        if (ram_rd) ram_rdata <= dev_mem[ram_addr[7:0]];
    end

    // Transaction-level expectations
    logic [31:0] exp_mem [WORDS];
    logic [31:0] exp_rdata;
    logic        exp_wp;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One in-window access; called at the start of a cycle with the bus idle
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        int          w;
        bit          prot;
        logic [31:0] cur;
        w    = int'((addr - BASE) >> 2);
        prot = WP_ON && (w < int'(WPW)) && (wstrb != 4'h0);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        #1;
        check("addr_map", 32'(ram_addr), 32'(addr[AB+1:2]));
        check("wdata_pass", ram_wdata, wdata);
        check("wr_strobe", 32'(ram_wr), prot ? 32'h0 : 32'(wstrb));
        check("rd_strobe", 32'(ram_rd), 32'(wstrb == 4'h0));
        check("ready_early", 32'(mem_ready), 32'h0);
        next_cycle();
        if (wstrb != 4'h0) begin
            if (prot) begin
                exp_wp = 1'b1;
            end else begin
                cur = exp_mem[w];
                for (int b = 0; b < 4; b++) if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                exp_mem[w] = cur;
            end
            check("wr_ack", 32'(mem_ready), 32'h1);
            check("rdata_hold", mem_rdata, exp_rdata);
            check("wp_flag", 32'(wp_violation), 32'(exp_wp));
        end else begin
            check("rd_wait_ready", 32'(mem_ready), 32'h0);
            check("rd_wait_strb", 32'(ram_rd), 32'h0);
            next_cycle();
            exp_rdata = exp_mem[w];
            check("rd_ack", 32'(mem_ready), 32'h1);
            check("rd_data", mem_rdata, exp_rdata);
        end
        // ACK cycle: request still valid but must not be taken
        check("ack_no_wr", 32'(ram_wr), 32'h0);
        check("ack_no_rd", 32'(ram_rd), 32'h0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        next_cycle();
        check("ready_pulse_end", 32'(mem_ready), 32'h0);
    endtask

    // Out-of-window request held for n cycles: no RAM activity, no ack
    task automatic outside(input logic [31:0] addr, input int n);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
        for (int i = 0; i < n; i++) begin
            #1;
            check("oow_wr", 32'(ram_wr), 32'h0);
            check("oow_rd", 32'(ram_rd), 32'h0);
            check("oow_ready", 32'(mem_ready), 32'h0);
            next_cycle();
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < int'(WORDS); i++) begin
            dev_mem[i] = $urandom;
            exp_mem[i] = dev_mem[i];
        end
        exp_rdata = 32'h0;
        exp_wp    = 1'b0;
        reset_    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        ram_rdata = 32'h0;
        #12;
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_wp", 32'(wp_violation), 32'h0);
        check("rst_wr", 32'(ram_wr), 32'h0);
        check("rst_rd", 32'(ram_rd), 32'h0);
        reset_ = 1'b1;
        next_cycle();

        // Full write, read-back, byte merge, read-back
        access(BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        access(BASE + 32'h10, 32'h0, 4'h0);
        check("readback_const", mem_rdata, 32'hDEADBEEF);
        access(BASE + 32'h10, 32'h0055_0000, 4'b0100);
        access(BASE + 32'h10, 32'h0, 4'h0);
        check("byte_merge_const", mem_rdata, 32'hDE55BEEF);

        // Window edges
        access(BASE + 32'h3FC, 32'hA5A5_5A5A, 4'hF);
        access(BASE + 32'h3FC, 32'h0, 4'h0);
        outside(BASE + 32'h400, 5);
        outside(32'hFFFF_FFFC, 2);
        next_cycle();

        // Reset asserted in RD_WAIT
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h10;
        mem_wstrb = 4'h0;
        next_cycle();
        reset_ = 1'b0;
        #1;
        check("midrst_ready", 32'(mem_ready), 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        check("midrst_wp", 32'(wp_violation), 32'h0);
        mem_valid = 1'b0;
        exp_rdata = 32'h0;
        exp_wp    = 1'b0;
        next_cycle();
        reset_ = 1'b1;
        next_cycle();
        access(BASE + 32'h10, 32'h0, 4'h0);

        // Write to a low (protectable) word, then read it back
        access(BASE + 32'h20, 32'h1234_5678, 4'hF);
        access(BASE + 32'h20, 32'h0, 4'h0);
        check("wp_sticky", 32'(wp_violation), 32'(WP_ON));

        // Randomized traffic with occasional out-of-window requests and idle gaps
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                outside(BASE + 32'h400 + 32'($urandom_range(0, 4095)), 2);
                next_cycle();
            end else begin
                a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
                s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                access(a, $urandom, s);
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) next_cycle();
            end
        end
        check("wp_final", 32'(wp_violation), 32'(exp_wp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/local_ram_if.md
Name: local_ram_if

Overview:
- CPU-side responder for the native valid/ready memory bus (picorv32-style mem_* signals).
- Also the initiator toward the byte-lane local RAM: it drives the RAM's byte write strobes, read enable, word address and write data, and captures its 1-cycle registered read data.
- Decodes its own address window, sequences each access with a small FSM, and returns mem_ready and mem_rdata to the CPU.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be WORDS*4 aligned
WORDS, 256, RAM depth in 32-bit words; must be a power of 2
ADDR_BITS, 11, width of ram_addr in bits; word index only
WP_WORDS, 64, count of write-protected low words; used only with LOCAL_RAM_IF_WP_EN

Ports:
clk  input  1  system clock
reset_  input  1  asynchronous, active-low reset
mem_valid  input  1  CPU request valid
mem_instr  input  1  request is an instruction fetch; informational only
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write strobes; 0 means read
mem_ready  output  1  one-cycle completion pulse
mem_rdata  output  32  read data, valid while mem_ready=1
ram_wr  output  4  RAM byte write enables
ram_rd  output  1  RAM read enable
ram_addr  output  ADDR_BITS  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, registered, available 1 cycle after ram_rd
wp_violation  output  1  sticky write-protect hit flag; tied 0 without the macro

Behaviour:
- Reset (reset_=0, asynchronous): state=IDLE; mem_ready=0, mem_rdata=0, wp_violation=0. RAM outputs follow the combinational rules below, so ram_wr=0 and ram_rd=0.
- sel = mem_valid && (mem_addr >= BASE_ADDR) && (mem_addr < BASE_ADDR + WORDS*4).
- ram_addr = mem_addr[ADDR_BITS+1:2] (combinational, always). ram_wdata = mem_wdata (combinational).
- mem_addr[1:0] is ignored; word-aligned accesses only.
- FSM states: IDLE, RD_WAIT, ACK.
- IDLE, sel=1, mem_wstrb!=0, cycle N:
  - ram_wr=mem_wstrb combinationally in cycle N.
  - Next state ACK; mem_ready=1 in cycle N+1.
  - Write latency: 1 cycle.
- IDLE, sel=1, mem_wstrb==0, cycle N:
  - ram_rd=1 combinationally in cycle N.
  - Next state RD_WAIT.
  - In RD_WAIT (cycle N+1), mem_rdata <= ram_rdata at the clock edge ending N+1; next state ACK.
  - mem_ready=1 in cycle N+2. Read latency: 2 cycles.
- ACK: mem_ready=1 for exactly one cycle, then IDLE unconditionally. No new request is accepted in the ACK cycle, even if mem_valid is still high.
- ram_wr=0 and ram_rd=0 in every state other than IDLE, and in IDLE whenever sel=0.
- sel=0 (address outside the window): no RAM access, mem_ready stays 0. Another slave responds.
- mem_rdata holds its last read value across writes and idle cycles; it is updated only in RD_WAIT.
- mem_valid dropped in RD_WAIT or ACK (protocol violation): the transaction still completes and mem_ready still pulses.
- Back-to-back requests: the next request is accepted at the earliest in the cycle after ACK.
- mem_instr has no effect on timing or data.

Optional Feature:
- Macro: LOCAL_RAM_IF_WP_EN.
- Defined:
  - A write in IDLE with sel=1 and word index < WP_WORDS forces ram_wr=0; the RAM is not modified.
  - The write is still acknowledged with normal 1-cycle latency.
  - wp_violation sets to 1 and stays set until reset.
  - Reads of protected words are unaffected.
- Undefined: no write protection; wp_violation is tied 0; WP_WORDS is unused.

Test Plan:
- Write, 1-cycle ack: mem_addr=0x0000_0010, mem_wdata=0xDEADBEEF, mem_wstrb=4'hF -> ram_wr=4'hF and ram_addr=4 in cycle N; mem_ready=1 only in N+1.
- Read-back, 2-cycle ack: after the previous write, read 0x10 with wstrb=0 -> ram_rd=1 in N; mem_ready=1 in N+2 with mem_rdata=0xDEADBEEF.
- Byte write then read: write 0x10 with wstrb=4'b0100, wdata=0x0055_0000 -> ram_wr=4'b0100; with the behavioural RAM model, a subsequent read of 0x10 returns 0xDE55BEEF.
- Out of window: mem_addr=BASE_ADDR+0x400 (WORDS=256), mem_valid held 5 cycles -> ram_wr=0, ram_rd=0, mem_ready never asserts.
- Reset mid-read: assert reset_=0 in the RD_WAIT cycle -> mem_ready=0 and mem_rdata=0 immediately; after release, the FSM is in IDLE and a fresh read completes in 2 cycles.
- With LOCAL_RAM_IF_WP_EN, WP_WORDS=64: write 0x0000_0020 (word 8) with 0x12345678 -> ram_wr=0, mem_ready at N+1, wp_violation=1 and sticky; a read of 0x20 returns the old value.
